// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART serial transmitter (start, LSB-first data, optional
//            parity, 1-2 stop bits) with a one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter logic [15:0] DIV_CNT   = 16'd434,
    parameter int          STOP_BITS = 1,
    parameter int          PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_end,
    output logic       tx_ovr,
    output logic       tx
);

    localparam logic [15:0] c_DIV_LAST  = DIV_CNT - 16'd1;
    localparam logic [15:0] c_DIV_PEN   = DIV_CNT - 16'd2;
    localparam logic        c_LAST_STOP = (STOP_BITS == 2);
    localparam logic        c_HAS_PAR   = (PARITY != 0);
    localparam logic        c_ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic [15:0] r_div;
    logic [2:0]  r_bit;
    logic        r_stop;
    logic        r_end;
    logic        r_ovr;

    logic        w_bit_end;
    logic        w_last_stop;
    logic        w_frame_done;
    logic        w_drop;
    logic        w_load_hold;

    assign w_bit_end    = (r_state != S_IDLE) && (r_div == c_DIV_LAST);
    assign w_last_stop  = (r_stop == c_LAST_STOP);
    assign w_frame_done = (r_state == S_STOP) && w_bit_end && w_last_stop;
    assign w_drop       = tx_start && r_hold_full;
    assign w_load_hold  = tx_start && (r_state != S_IDLE) && !r_hold_full && !w_frame_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A start coinciding with the frame-done edge chains directly into START
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (tx_start) w_state_next = S_START;
            S_START:  if (w_bit_end) w_state_next = S_DATA;
            S_DATA:   if (w_bit_end && (r_bit == 3'd7))
                          w_state_next = c_HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
            S_STOP:   if (w_frame_done)
                          w_state_next = (r_hold_full || tx_start) ? S_START : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_div       <= 16'd0;
            r_bit       <= 3'd0;
            r_stop      <= 1'b0;
            r_end       <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_ovr <= w_drop;
            r_end <= (r_state == S_STOP) && w_last_stop && (r_div == c_DIV_PEN);

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_div <= 16'd0;
            end else begin
                r_div <= r_div + 16'd1;
            end

            if ((r_state == S_DATA) && w_bit_end) begin
                r_bit <= r_bit + 3'd1;
            end

            if (w_frame_done) begin
                r_stop <= 1'b0;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_stop <= 1'b1;
            end

            if ((r_state == S_IDLE) && tx_start) begin
                r_shift <= tx_data;
            end else if (w_frame_done) begin
                if (r_hold_full) begin
                    r_shift     <= r_hold;
                    r_hold_full <= 1'b0;
                end else if (tx_start) begin
                    r_shift <= tx_data;
                end
            end else if (w_load_hold) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // Shift register is indexed rather than shifted so parity sees the whole byte
    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[r_bit];
            S_PARITY: tx = (^r_shift) ^ c_ODD;
            default:  tx = 1'b1;
        endcase
    end

    assign tx_busy = (r_state != S_IDLE) || r_hold_full;
    assign tx_end  = r_end;
    assign tx_ovr  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a frame-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       start [3];
    logic [7:0] data  [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       tend  [3];
    logic       ovr   [3];

    uart_tx #(.DIV_CNT(16'd4), .STOP_BITS(1), .PARITY(0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]),
        .tx_busy(busy[0]), .tx_end(tend[0]), .tx_ovr(ovr[0]), .tx(tx[0]));
    uart_tx #(.DIV_CNT(16'd4), .STOP_BITS(2), .PARITY(2)) u_dut1 (
        .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]),
        .tx_busy(busy[1]), .tx_end(tend[1]), .tx_ovr(ovr[1]), .tx(tx[1]));
    uart_tx #(.DIV_CNT(16'd4), .STOP_BITS(2), .PARITY(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]),
        .tx_busy(busy[2]), .tx_end(tend[2]), .tx_ovr(ovr[2]), .tx(tx[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc;
    int         fs[$];
    logic [7:0] fb[$];
    int         drops[$];
    int         m_last_end;
    int         m_hold_until;
    logic [3:0] got;
    logic [3:0] want;

    function automatic int par_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic int stop_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int flen(int k);
        return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
    endfunction

    function automatic logic frame_bit(int k, logic [7:0] b, int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == 9 && par_of(k) != 0) return (^b) ^ (par_of(k) == 1);
        return 1'b1;
    endfunction

    // Requests are scheduled as whole frames: [start edge, start edge + F*D)
    task automatic model_req(int k, int t, logic [7:0] b);
        if (m_hold_until >= 0 && t <= m_hold_until) begin
            drops.push_back(t);
        end else if (t >= m_last_end) begin
            fs.push_back(t);
            fb.push_back(b);
            m_last_end = t + flen(k) * D;
        end else begin
            fs.push_back(m_last_end);
            fb.push_back(b);
            m_hold_until = m_last_end;
            m_last_end   = m_last_end + flen(k) * D;
        end
    endtask

    function automatic logic exp_tx(int k, int e);
        foreach (fs[i])
            if (e >= fs[i] && e < fs[i] + flen(k) * D)
                return frame_bit(k, fb[i], (e - fs[i]) / D);
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int k, int e);
        foreach (fs[i])
            if (e >= fs[i] && e < fs[i] + flen(k) * D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_end(int k, int e);
        foreach (fs[i])
            if (e == fs[i] + flen(k) * D - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_ovr(int e);
        foreach (drops[i])
            if (drops[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic begin_scenario();
        for (int j = 0; j < 3; j++) begin
            start[j] = 1'b0;
            data[j]  = 8'h00;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fs.delete();
        fb.delete();
        drops.delete();
        m_last_end   = 0;
        m_hold_until = -1;
        cyc          = 0;
    endtask

    // Drive one cycle of stimulus, advance one edge, sample 1 time unit later
    task automatic step(int k, logic s, logic [7:0] d);
        start[k] = s;
        data[k]  = d;
        @(posedge clk);
        cyc = cyc + 1;
        if (s) model_req(k, cyc, d);
        #1;
        start[k] = 1'b0;
        data[k]  = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            start[j] = 1'b0;
            data[j]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            got = {tx[j], busy[j], tend[j], ovr[j]};
            n_checks++;
            if (got !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset dut%0d {tx,busy,end,ovr} got=%b want=1000", j, got);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        begin_scenario();
        for (int i = 0; i < 50; i++) begin
            step(0, i == 0, 8'h55);
            got  = {tx[0], busy[0], tend[0], ovr[0]};
            want = {exp_tx(0, cyc), exp_busy(0, cyc), exp_end(0, cyc), exp_ovr(cyc)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single cyc=%0d {tx,busy,end,ovr} got=%b want=%b", cyc, got, want);
            end
        end
    endtask

    task automatic test_parity();
        for (int k = 1; k < 3; k++) begin
            begin_scenario();
            for (int i = 0; i < 55; i++) begin
                step(k, i == 0, 8'h07);
                got  = {tx[k], busy[k], tend[k], ovr[k]};
                want = {exp_tx(k, cyc), exp_busy(k, cyc), exp_end(k, cyc), exp_ovr(cyc)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL parity dut%0d cyc=%0d {tx,busy,end,ovr} got=%b want=%b", k, cyc, got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        begin_scenario();
        for (int i = 0; i < 90; i++) begin
            step(0, (i == 0) || (i == 10), (i == 0) ? 8'hA5 : 8'h3C);
            got  = {tx[0], busy[0], tend[0], ovr[0]};
            want = {exp_tx(0, cyc), exp_busy(0, cyc), exp_end(0, cyc), exp_ovr(cyc)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d {tx,busy,end,ovr} got=%b want=%b", cyc, got, want);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        begin_scenario();
        for (int i = 0; i < 90; i++) begin
            b = (i == 0) ? 8'h11 : ((i == 5) ? 8'h22 : 8'h33);
            step(0, (i == 0) || (i == 5) || (i == 6), b);
            got  = {tx[0], busy[0], tend[0], ovr[0]};
            want = {exp_tx(0, cyc), exp_busy(0, cyc), exp_end(0, cyc), exp_ovr(cyc)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL overrun cyc=%0d {tx,busy,end,ovr} got=%b want=%b", cyc, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        begin_scenario();
        for (int i = 0; i < 18; i++) step(0, i == 0, 8'hC3);
        #2;
        rst = 1'b0;
        #1;
        got = {tx[0], busy[0], tend[0], ovr[0]};
        n_checks++;
        if (got !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid {tx,busy,end,ovr} got=%b want=1000", got);
        end
        @(negedge clk);
        rst = 1'b1;
        fs.delete();
        fb.delete();
        drops.delete();
        m_last_end   = 0;
        m_hold_until = -1;
        cyc          = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, i == 2, 8'hF0);
            got  = {tx[0], busy[0], tend[0], ovr[0]};
            want = {exp_tx(0, cyc), exp_busy(0, cyc), exp_end(0, cyc), exp_ovr(cyc)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc=%0d {tx,busy,end,ovr} got=%b want=%b", cyc, got, want);
            end
        end
    endtask

    task automatic test_coincident();
        begin_scenario();
        for (int i = 0; i < 90; i++) begin
            step(0, (i == 0) || (i == 40), (i == 0) ? 8'h5A : 8'h81);
            got  = {tx[0], busy[0], tend[0], ovr[0]};
            want = {exp_tx(0, cyc), exp_busy(0, cyc), exp_end(0, cyc), exp_ovr(cyc)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL coincident cyc=%0d {tx,busy,end,ovr} got=%b want=%b", cyc, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic s;
        for (int k = 0; k < 3; k++) begin
            begin_scenario();
            for (int i = 0; i < 800; i++) begin
                s = (i < 680) && ($urandom_range(0, 99) < 6);
                step(k, s, 8'($urandom));
                got  = {tx[k], busy[k], tend[k], ovr[k]};
                want = {exp_tx(k, cyc), exp_busy(k, cyc), exp_end(k, cyc), exp_ovr(cyc)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc=%0d {tx,busy,end,ovr} got=%b want=%b", k, cyc, got, want);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_coincident();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
